traffic_input_conditioner: RTL and testbench
============================================

# traffic_input_conditioner

Front-end conditioner for the traffic-light controller's inputs: it synchronizes, debounces, and latches the two active-low pedestrian crosswalk buttons, and qualifies the three vehicle-loop detectors. It sits between the board pins and the light controller. Pedestrian requests are held until the controller acknowledges them. Vehicle presence is reported only after a detector has been stable for a set time, so glitches and passing cars never trigger a phase change.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable sysclk cycles needed to accept a button level change (20 ms at 50 MHz); must be ≥2
- PRESENCE_CYCLES, 50000000, consecutive high sysclk cycles needed to assert vehicle presence (1 s at 50 MHz); must be ≥2
- DROPOUT_CYCLES, 1000000, consecutive low sysclk cycles needed to deassert vehicle presence; must be ≥2
- CNT_W, 26, counter width; must hold max(DEBOUNCE_CYCLES, PRESENCE_CYCLES, DROPOUT_CYCLES)
- sysclk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- btn_cr_n  in  1  raw cross-street crosswalk button, active-low, asynchronous
- btn_mn_n  in  1  raw main-street crosswalk button, active-low, asynchronous
- det_straight_cr, det_turn_cr, det_turn_mn  in  1 each  raw loop detectors, active-high, asynchronous
- ack_cr, ack_mn  in  1 each  one-cycle pulse from controller: request consumed (crosswalk timer started)
- req_cr, req_mn  out  1 each  latched pedestrian request, active-high
- straight_cr, turn_cr, turn_mn  out  1 each  qualified vehicle presence, active-high

## Operation
- Every raw input passes through a 2-flop synchronizer. Flops reset to the inactive level: 1 for buttons, 0 for detectors.
- Per-button debounce FSM on the synchronized active-high pressed signal `p`:
  - RELEASED: if p=1, clear counter and go to PRESS_CHK.
  - PRESS_CHK: if p=0, go to RELEASED. Otherwise count; when count reaches DEBOUNCE_CYCLES-1, go to PRESSED and emit a one-cycle `press` pulse.
  - PRESSED: if p=0, clear counter and go to REL_CHK.
  - REL_CHK: if p=1, go to PRESSED. Otherwise count; when count reaches DEBOUNCE_CYCLES-1, go to RELEASED.
  - Bounce during a CHK state returns to the prior stable state with no pulse.
- Request latch per button:
  - `press` sets req.
  - ack clears req.
  - `press` and ack in the same cycle: req is 1 (the new press wins).
  - ack while req=0: no effect.
  - A held button produces exactly one `press`. No re-request until the button is released (through REL_CHK) and pressed again.
- Presence qualifier per detector, with states ABSENT and PRESENT:
  - In ABSENT, the counter increments while the synced input is 1 and clears to 0 on any 0. Output goes to 1 when the count reaches PRESENCE_CYCLES-1 with the input still 1.
  - In PRESENT, the same rule applies with the input sense inverted and DROPOUT_CYCLES as the threshold.
  - Counters saturate; they never wrap.
- The five channels are independent, with no shared counters.

## Timing
- Reset values: req_cr=0, req_mn=0, straight_cr=0, turn_cr=0, turn_mn=0. All FSMs start in RELEASED/ABSENT with counters at 0. Reset mid-count discards partial counts and any pending request.
- Button latency: raw press stable from edge k gives req=1 after edge k+2+DEBOUNCE_CYCLES, i.e. observable DEBOUNCE_CYCLES+2 edges after first sample.
- Detector latency:
  - Raw rise stable from edge k gives output=1 after edge k+2+PRESENCE_CYCLES.
  - Raw fall gives output=0 after edge k+2+DROPOUT_CYCLES.
- ack clears req on the edge that samples ack=1, so req=0 the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, PRESENCE_CYCLES=8, DROPOUT_CYCLES=4.
- Clean press: btn_cr_n low from edge 10 and held → req_cr=1 after edge 16. No second rise while held. After ack_cr pulse at edge 20, req_cr=0 from edge 21 and stays 0 while the button is held.
- Bounce: btn_mn_n toggles low/high every 2 cycles for 20 cycles, then stays high → req_mn stays 0 throughout.
- Simultaneous events: a second press completes debounce on the same edge as an ack_cr pulse → req_cr remains 1.
- Presence: det_turn_cr high for 7 cycles, low 1, high 8 → turn_cr stays 0 through the first burst and goes 1 after edge (start of second burst + 10). Then a 3-cycle low glitch leaves turn_cr at 1, and a 4-cycle low deasserts it.
- Async reset: assert rst_n=0 mid-PRESS_CHK and with turn_mn=1 → all outputs 0 immediately, without waiting for a clock edge. After release with the inputs idle, outputs stay 0.
- Independence: press both buttons and raise all detectors simultaneously → both req_cr and req_mn rise on the same edge. Each detector output rises at the expected edge. ack_mn clears only req_mn.

Source files
------------

// File: rtl/traffic_input_conditioner_if.sv
// traffic_input_conditioner_if: board-pin and controller signals of the input conditioner.
// Ports:
//   btn_cr_n, btn_mn_n                      raw active-low crosswalk buttons
//   det_straight_cr, det_turn_cr, det_turn_mn raw active-high loop detectors
//   ack_cr, ack_mn                          one-cycle request-consumed pulses from the controller
//   req_cr, req_mn                          latched pedestrian requests
//   straight_cr, turn_cr, turn_mn           qualified vehicle presence
// master drives the raw inputs and acks; slave is the conditioner.
interface traffic_input_conditioner_if;
    logic btn_cr_n;
    logic btn_mn_n;
    logic det_straight_cr;
    logic det_turn_cr;
    logic det_turn_mn;
    logic ack_cr;
    logic ack_mn;
    logic req_cr;
    logic req_mn;
    logic straight_cr;
    logic turn_cr;
    logic turn_mn;
    modport master (
        output btn_cr_n, btn_mn_n, det_straight_cr, det_turn_cr, det_turn_mn, ack_cr, ack_mn,
        input  req_cr, req_mn, straight_cr, turn_cr, turn_mn
    );
    modport slave (
        input  btn_cr_n, btn_mn_n, det_straight_cr, det_turn_cr, det_turn_mn, ack_cr, ack_mn,
        output req_cr, req_mn, straight_cr, turn_cr, turn_mn
    );
endinterface

// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner: synchronizes, debounces and latches crosswalk buttons; qualifies loop detectors.
// Ports:
//   sysclk  system clock
//   rst_n   asynchronous active-low reset
//   bus     traffic_input_conditioner_if.slave: raw buttons/detectors and acks in,
//           latched requests and qualified presence out (all outputs registered)
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PRESENCE_CYCLES = 50000000,
    parameter int DROPOUT_CYCLES  = 1000000,
    parameter int CNT_W           = 26
) (
    input logic                         sysclk,
    input logic                         rst_n,
    traffic_input_conditioner_if.slave  bus
);
    localparam logic [1:0] RELEASED  = 2'd0;
    localparam logic [1:0] PRESS_CHK = 2'd1;
    localparam logic [1:0] PRESSED   = 2'd2;
    localparam logic [1:0] REL_CHK   = 2'd3;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PR_MAX = CNT_W'(PRESENCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DO_MAX = CNT_W'(DROPOUT_CYCLES - 1);

    logic [1:0] btn_s1_q, btn_s2_q;
    logic [2:0] det_s1_q, det_s2_q;
    logic [1:0] ack;
    logic [1:0] req;
    logic [2:0] pres;

    assign ack = {bus.ack_mn, bus.ack_cr};

    // Two-flop synchronizers; buttons idle high, detectors idle low.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
            det_s1_q <= 3'b000;
            det_s2_q <= 3'b000;
        end else begin
            btn_s1_q <= {bus.btn_mn_n, bus.btn_cr_n};
            btn_s2_q <= btn_s1_q;
            det_s1_q <= {bus.det_turn_mn, bus.det_turn_cr, bus.det_straight_cr};
            det_s2_q <= det_s1_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]       st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             req_q, req_d;
        logic             p, press;
        assign p = ~btn_s2_q[b];
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            press = 1'b0;
            case (st_q)
                RELEASED: if (p) begin
                    st_d  = PRESS_CHK;
                    cnt_d = '0;
                end
                PRESS_CHK: if (!p) st_d = RELEASED;
                else if (cnt_q == DB_MAX) begin
                    st_d  = PRESSED;
                    press = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
                PRESSED: if (!p) begin
                    st_d  = REL_CHK;
                    cnt_d = '0;
                end
                default: if (p) st_d = PRESSED;
                else if (cnt_q == DB_MAX) st_d = RELEASED;
                else cnt_d = cnt_q + 1'b1;
            endcase
            // A fresh press outranks an ack arriving on the same edge.
            req_d = press | (req_q & ~ack[b]);
        end
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= RELEASED;
                cnt_q <= '0;
                req_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                req_q <= req_d;
            end
        end
        assign req[b] = req_q;
    end

    for (genvar d = 0; d < 3; d++) begin : g_det
        logic             pres_q, pres_d, out_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             in;
        assign in = det_s2_q[d];
        // Count samples that disagree with the current state; any agreeing sample restarts the count.
        // The count stops at its threshold, so it never wraps.
        always_comb begin
            pres_d = pres_q;
            cnt_d  = '0;
            if (in != pres_q) begin
                if (cnt_q == (pres_q ? DO_MAX : PR_MAX)) pres_d = in;
                else cnt_d = cnt_q + 1'b1;
            end
        end
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                pres_q <= 1'b0;
                cnt_q  <= '0;
                out_q  <= 1'b0;
            end else begin
                pres_q <= pres_d;
                cnt_q  <= cnt_d;
                out_q  <= pres_q;
            end
        end
        assign pres[d] = out_q;
    end

    assign bus.req_cr      = req[0];
    assign bus.req_mn      = req[1];
    assign bus.straight_cr = pres[0];
    assign bus.turn_cr     = pres[1];
    assign bus.turn_mn     = pres[2];
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb_traffic_input_conditioner: scoreboard bench for the traffic input conditioner.
module tb_traffic_input_conditioner;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;

    traffic_input_conditioner_if bus();

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .PRESENCE_CYCLES(8),
        .DROPOUT_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .sysclk(sysclk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 sysclk = ~sysclk;

    // Edge n is the n-th rising edge after reset release.
    always @(posedge sysclk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    typedef struct {
        int    at;
        int    idx;
        logic  v;
        string tag;
    } exp_t;
    exp_t sb[$];

    logic [4:0] obs;
    assign obs = {bus.turn_mn, bus.turn_cr, bus.straight_cr, bus.req_mn, bus.req_cr};

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    task automatic expect_span(input int from, input int to, input int idx, input logic v, input string tag);
        for (int c = from; c <= to; c++) sb.push_back('{c, idx, v, tag});
    endtask

    // Stimulus changes at the falling edge just before edge k, so it is stable from edge k.
    task automatic go(input int k);
        while (cyc < k - 1) @(negedge sysclk);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 1'b0, 1'b1);
            sb.delete();
        end
    endtask

    always @(negedge sysclk) begin : monitor
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                if (sb[i].at < cyc) chk($sformatf("%s@%0d_missed", sb[i].tag, sb[i].at), 1'b0, 1'b1);
                else chk($sformatf("%s@%0d", sb[i].tag, sb[i].at), obs[sb[i].idx], sb[i].v);
                sb.delete(i);
            end
        end
    end

    task automatic idle_inputs();
        bus.btn_cr_n        = 1'b1;
        bus.btn_mn_n        = 1'b1;
        bus.det_straight_cr = 1'b0;
        bus.det_turn_cr     = 1'b0;
        bus.det_turn_mn     = 1'b0;
        bus.ack_cr          = 1'b0;
        bus.ack_mn          = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 5; i++) chk($sformatf("reset_out%0d", i), obs[i], 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) expect_span(1, 5, i, 1'b0, "init");

        // Clean press on the cross-street button, then ack while still held.
        go(10); bus.btn_cr_n = 1'b0;
        expect_span(10, 15, 0, 1'b0, "a_debounce");
        expect_span(16, 19, 0, 1'b1, "a_req");
        go(20); bus.ack_cr = 1'b1;
        expect_span(20, 30, 0, 1'b0, "a_acked_held");
        go(21); bus.ack_cr = 1'b0;
        go(31); bus.btn_cr_n = 1'b1;

        // Second press completes on the same edge that samples an ack.
        go(40); bus.btn_cr_n = 1'b0;
        expect_span(40, 45, 0, 1'b0, "c_debounce");
        expect_span(46, 55, 0, 1'b1, "c_press_wins");
        go(46); bus.ack_cr = 1'b1;
        go(47); bus.ack_cr = 1'b0;
        go(50); bus.btn_cr_n = 1'b1;

        // Bouncing main-street button never produces a request.
        expect_span(60, 90, 1, 1'b0, "b_bounce");
        for (int j = 0; j < 5; j++) begin
            go(60 + 4 * j); bus.btn_mn_n = 1'b0;
            go(62 + 4 * j); bus.btn_mn_n = 1'b1;
        end

        // Presence: short burst ignored, long burst qualifies, short dropout ignored.
        go(100); bus.det_turn_cr = 1'b1;
        expect_span(100, 117, 3, 1'b0, "d_short_burst");
        expect_span(118, 118, 3, 1'b1, "d_rise");
        go(107); bus.det_turn_cr = 1'b0;
        go(108); bus.det_turn_cr = 1'b1;
        expect_span(119, 155, 3, 1'b1, "d_hold");
        go(130); bus.det_turn_cr = 1'b0;
        go(133); bus.det_turn_cr = 1'b1;
        go(150); bus.det_turn_cr = 1'b0;
        go(154); bus.det_turn_cr = 1'b1;
        expect_span(156, 163, 3, 1'b0, "d_dropout");
        expect_span(164, 168, 3, 1'b1, "d_return");
        go(170); bus.det_turn_cr = 1'b0;
        expect_span(176, 180, 3, 1'b0, "d_off");

        // Asynchronous reset with outputs active and a press mid-debounce.
        go(180); bus.det_turn_mn = 1'b1;
        expect_span(189, 189, 4, 1'b0, "e_pre_rise");
        expect_span(190, 197, 4, 1'b1, "e_present");
        expect_span(190, 197, 0, 1'b1, "e_req_cr_held");
        go(195); bus.btn_mn_n = 1'b0;
        go(199);
        chk("e_sb_empty", sb.size() == 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) chk($sformatf("e_async_out%0d", i), obs[i], 1'b0);
        idle_inputs();
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) expect_span(1, 20, i, 1'b0, "e_post_reset");

        // Independence: everything at once, ack only the main-street request.
        go(30);
        bus.btn_cr_n        = 1'b0;
        bus.btn_mn_n        = 1'b0;
        bus.det_straight_cr = 1'b1;
        bus.det_turn_cr     = 1'b1;
        bus.det_turn_mn     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_span(35, 35, i, 1'b0, "f_req_pre");
            expect_span(36, 36, i, 1'b1, "f_req_rise");
        end
        expect_span(37, 50, 0, 1'b1, "f_req_cr_kept");
        expect_span(37, 44, 1, 1'b1, "f_req_mn_held");
        for (int i = 2; i < 5; i++) begin
            expect_span(39, 39, i, 1'b0, "f_det_pre");
            expect_span(40, 50, i, 1'b1, "f_det_rise");
        end
        go(45); bus.ack_mn = 1'b1;
        expect_span(45, 50, 1, 1'b0, "f_req_mn_acked");
        go(46); bus.ack_mn = 1'b0;

        drain(100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
